// File: rtl/collision_scan_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | collision_scan_pkg : shared types, geometry defaults, width helpers   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package collision_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } scan_state_t;

    localparam int C_PLAYER_W = 16;
    localparam int C_PLAYER_H = 16;
    localparam int C_OBS_W    = 32;
    localparam int C_OBS_H    = 32;
    localparam int C_PAD      = 2;

    localparam int C_X_W   = 10;
    localparam int C_Y_W   = 9;
    localparam int C_CMP_W = 11;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/collision_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | collision_scan_ctrl_if : indexed read port to the obstacle store      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface collision_scan_ctrl_if
    import collision_scan_pkg::*;
#(
    parameter int NUM_ROWS          = 6,
    parameter int OBSTACLES_PER_ROW = 10
) ();

    logic                                 rd_valid;
    logic [idx_w(NUM_ROWS)-1:0]           rd_row;
    logic [idx_w(OBSTACLES_PER_ROW)-1:0]  rd_col;
    logic [C_X_W-1:0]                     obs_x;
    logic [C_Y_W-1:0]                     obs_y;

    modport master (output rd_valid, rd_row, rd_col, input  obs_x, obs_y);
    modport slave  (input  rd_valid, rd_row, rd_col, output obs_x, obs_y);

endinterface
`default_nettype wire

// File: rtl/aabb_overlap.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | aabb_overlap : strict inset box-overlap test, 11-bit so sums never wrap|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module aabb_overlap
    import collision_scan_pkg::*;
#(
    parameter int PLAYER_W = C_PLAYER_W,
    parameter int PLAYER_H = C_PLAYER_H,
    parameter int OBS_W    = C_OBS_W,
    parameter int OBS_H    = C_OBS_H,
    parameter int PAD      = C_PAD
) (
    input  logic [C_X_W-1:0] px,
    input  logic [C_Y_W-1:0] py,
    input  logic [C_X_W-1:0] ox,
    input  logic [C_Y_W-1:0] oy,
    output logic             overlap
);

    localparam logic [C_CMP_W-1:0] c_pad   = C_CMP_W'(PAD);
    localparam logic [C_CMP_W-1:0] c_ply_w = C_CMP_W'(PLAYER_W - PAD);
    localparam logic [C_CMP_W-1:0] c_ply_h = C_CMP_W'(PLAYER_H - PAD);
    localparam logic [C_CMP_W-1:0] c_obs_w = C_CMP_W'(OBS_W - PAD);
    localparam logic [C_CMP_W-1:0] c_obs_h = C_CMP_W'(OBS_H - PAD);

    logic [C_CMP_W-1:0] w_px, w_py, w_ox, w_oy;

    assign w_px = C_CMP_W'(px);
    assign w_py = C_CMP_W'(py);
    assign w_ox = C_CMP_W'(ox);
    assign w_oy = C_CMP_W'(oy);

    assign overlap = (w_px + c_pad   < w_ox + c_obs_w) &&
                     (w_px + c_ply_w > w_ox + c_pad)   &&
                     (w_py + c_pad   < w_oy + c_obs_h) &&
                     (w_py + c_ply_h > w_oy + c_pad);

endmodule
`default_nettype wire

// File: rtl/collision_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | collision_scan_ctrl : per-frame sequential obstacle collision scan    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module collision_scan_ctrl
    import collision_scan_pkg::*;
#(
    parameter int NUM_ROWS          = 6,
    parameter int OBSTACLES_PER_ROW = 10,
    parameter int PLAYER_W          = C_PLAYER_W,
    parameter int PLAYER_H          = C_PLAYER_H,
    parameter int OBS_W             = C_OBS_W,
    parameter int OBS_H             = C_OBS_H,
    parameter int PAD               = C_PAD
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                scan_start,
    input  logic                                enable,
    input  logic [C_X_W-1:0]                    player_x,
    input  logic [C_Y_W-1:0]                    player_y,
    collision_scan_ctrl_if.master               rd,
    output logic                                busy,
    output logic                                done,
    output logic                                collision,
    output logic [idx_w(NUM_ROWS)-1:0]          hit_row,
    output logic [idx_w(OBSTACLES_PER_ROW)-1:0] hit_col
);

    localparam int RW = idx_w(NUM_ROWS);
    localparam int CW = idx_w(OBSTACLES_PER_ROW);
    localparam logic [RW-1:0] c_last_row = RW'(NUM_ROWS - 1);
    localparam logic [CW-1:0] c_last_col = CW'(OBSTACLES_PER_ROW - 1);

    scan_state_t      r_state, w_state_nxt;
    logic [RW-1:0]    r_row, r_row_d, r_acc_row, w_acc_row_nxt;
    logic [CW-1:0]    r_col, r_col_d, r_acc_col, w_acc_col_nxt;
    logic [C_X_W-1:0] r_px;
    logic [C_Y_W-1:0] r_py;
    logic             r_vld_d, r_acc_hit;
    logic             w_start, w_last, w_rd_valid, w_overlap, w_first_hit, w_acc_hit_nxt;

    assign w_start = scan_start & enable;
    assign w_last  = (r_row == c_last_row) && (r_col == c_last_col);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_valid  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_start) w_state_nxt = ST_SCAN;
            ST_SCAN: begin
                busy       = 1'b1;
                w_rd_valid = enable;
                if (!enable)     w_state_nxt = ST_IDLE;
                else if (w_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy        = 1'b1;
                w_state_nxt = enable ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Row-major index walk plus the player snapshot taken at scan start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
            r_px  <= '0;
            r_py  <= '0;
        end else if (r_state == ST_IDLE && w_start) begin
            r_row <= '0;
            r_col <= '0;
            r_px  <= player_x;
            r_py  <= player_y;
        end else if (w_rd_valid) begin
            if (r_col == c_last_col) begin
                r_col <= '0;
                if (!w_last) r_row <= r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    aabb_overlap #(
        .PLAYER_W (PLAYER_W),
        .PLAYER_H (PLAYER_H),
        .OBS_W    (OBS_W),
        .OBS_H    (OBS_H),
        .PAD      (PAD)
    ) u_overlap (
        .px      (r_px),
        .py      (r_py),
        .ox      (rd.obs_x),
        .oy      (rd.obs_y),
        .overlap (w_overlap)
    );

    assign w_first_hit   = r_vld_d & w_overlap & ~r_acc_hit;
    assign w_acc_hit_nxt = r_acc_hit | (r_vld_d & w_overlap);
    assign w_acc_row_nxt = w_first_hit ? r_row_d : r_acc_row;
    assign w_acc_col_nxt = w_first_hit ? r_col_d : r_acc_col;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_d   <= 1'b0;
            r_row_d   <= '0;
            r_col_d   <= '0;
            r_acc_hit <= 1'b0;
            r_acc_row <= '0;
            r_acc_col <= '0;
        end else begin
            r_vld_d <= w_rd_valid;
            r_row_d <= r_row;
            r_col_d <= r_col;
            if (r_state == ST_IDLE && w_start) begin
                r_acc_hit <= 1'b0;
                r_acc_row <= '0;
                r_acc_col <= '0;
            end else begin
                r_acc_hit <= w_acc_hit_nxt;
                r_acc_row <= w_acc_row_nxt;
                r_acc_col <= w_acc_col_nxt;
            end
        end
    end

    // The final obstacle compares in DRAIN, so results load from the next-accumulator value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision <= 1'b0;
            hit_row   <= '0;
            hit_col   <= '0;
        end else if (r_state == ST_DRAIN && enable) begin
            collision <= w_acc_hit_nxt;
            hit_row   <= w_acc_row_nxt;
            hit_col   <= w_acc_col_nxt;
        end else if (r_state == ST_IDLE && !enable) begin
            collision <= 1'b0;
            hit_row   <= '0;
            hit_col   <= '0;
        end
    end

    assign rd.rd_valid = w_rd_valid;
    assign rd.rd_row   = r_row;
    assign rd.rd_col   = r_col;

endmodule
`default_nettype wire

// File: tb/tb_collision_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_collision_scan_ctrl : directed checks of the collision scan        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_collision_scan_ctrl;

    localparam int NR  = 6;
    localparam int OPR = 10;
    localparam int N   = NR * OPR;

    logic       clk = 1'b0;
    logic       reset;
    logic       scan_start;
    logic       enable;
    logic [9:0] player_x;
    logic [8:0] player_y;
    logic       busy, done, collision;
    logic [2:0] hit_row;
    logic [3:0] hit_col;

    logic [9:0] mem_x [N];
    logic [8:0] mem_y [N];

    int n_chk = 0;
    int n_err = 0;
    int lat, nrd, ndone;

    collision_scan_ctrl_if #(.NUM_ROWS(NR), .OBSTACLES_PER_ROW(OPR)) rdif ();

    collision_scan_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .scan_start (scan_start),
        .enable     (enable),
        .player_x   (player_x),
        .player_y   (player_y),
        .rd         (rdif),
        .busy       (busy),
        .done       (done),
        .collision  (collision),
        .hit_row    (hit_row),
        .hit_col    (hit_col)
    );

    always #5 clk = ~clk;

    // Obstacle store: data returns one cycle after the request
    always @(posedge clk) begin
        if (rdif.rd_valid) begin
            rdif.obs_x <= mem_x[int'(rdif.rd_row) * OPR + int'(rdif.rd_col)];
            rdif.obs_y <= mem_y[int'(rdif.rd_row) * OPR + int'(rdif.rd_col)];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_far();
        for (int i = 0; i < N; i++) begin
            mem_x[i] = 10'd400;
            mem_y[i] = 9'd300;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_rdv"}, 32'(rdif.rd_valid), 0);
        chk({tag, "_coll"}, 32'(collision), 0);
        chk({tag, "_hrow"}, 32'(hit_row), 0);
        chk({tag, "_hcol"}, 32'(hit_col), 0);
        chk({tag, "_rrow"}, 32'(rdif.rd_row), 0);
        chk({tag, "_rcol"}, 32'(rdif.rd_col), 0);
    endtask

    // act: 0 plain, 1 snapshot/re-trigger at +10, 2 abort at +20, 3 reset at +30, 4 start in DONE
    task automatic run_scan(input int act, output int o_lat, output int o_nrd, output int o_ndone);
        o_lat = 0; o_nrd = 0; o_ndone = 0;
        @(negedge clk);
        scan_start = 1'b1;
        enable     = 1'b1;
        @(posedge clk); #1;
        scan_start = 1'b0;
        for (int k = 1; k <= 70; k++) begin
            if (act == 1 && k == 10) begin player_x = 10'd400; player_y = 9'd300; scan_start = 1'b1; end
            if (act == 1 && k == 11) scan_start = 1'b0;
            if (act == 2 && k == 20) enable = 1'b0;
            if (act == 2 && k == 21) enable = 1'b1;
            if (act == 3 && k == 30) begin
                reset = 1'b1;
                #1;
                check_all_zero("async_rst");
                #2;
                reset = 1'b0;
            end
            if (act == 4 && k == 62) scan_start = 1'b1;
            if (act == 4 && k == 63) scan_start = 1'b0;
            if (rdif.rd_valid) o_nrd++;
            if (done) begin
                o_ndone++;
                if (o_lat == 0) o_lat = k;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1; scan_start = 1'b0; enable = 1'b0;
        player_x = 10'd100; player_y = 9'd100;
        rdif.obs_x = '0; rdif.obs_y = '0;
        set_far();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;
        enable = 1'b1;

        // No overlap
        run_scan(0, lat, nrd, ndone);
        chk("far_latency", 32'(lat), 62);
        chk("far_rd_cycles", 32'(nrd), 60);
        chk("far_ndone", 32'(ndone), 1);
        chk("far_coll", 32'(collision), 0);
        chk("far_hrow", 32'(hit_row), 0);
        chk("far_hcol", 32'(hit_col), 0);

        // Single hit at [2][5]
        mem_x[25] = 10'd110; mem_y[25] = 9'd105;
        run_scan(0, lat, nrd, ndone);
        chk("hit_coll", 32'(collision), 1);
        chk("hit_hrow", 32'(hit_row), 2);
        chk("hit_hcol", 32'(hit_col), 5);

        // Later hit at [4][1] must not displace the first
        mem_x[41] = 10'd110; mem_y[41] = 9'd105;
        run_scan(0, lat, nrd, ndone);
        chk("prio_coll", 32'(collision), 1);
        chk("prio_hrow", 32'(hit_row), 2);
        chk("prio_hcol", 32'(hit_col), 5);

        // Edges: 114 > 114 fails (touch), 114 > 113 passes
        set_far();
        mem_x[7] = 10'd114; mem_y[7] = 9'd100;
        run_scan(0, lat, nrd, ndone);
        chk("edge114_coll", 32'(collision), 0);
        mem_x[7] = 10'd112;
        run_scan(0, lat, nrd, ndone);
        chk("touch_coll", 32'(collision), 0);
        mem_x[7] = 10'd111;
        run_scan(0, lat, nrd, ndone);
        chk("near_coll", 32'(collision), 1);
        chk("near_hrow", 32'(hit_row), 0);
        chk("near_hcol", 32'(hit_col), 7);

        // No 10-bit wrap; last index compared in DRAIN
        set_far();
        player_x = 10'd1015;
        mem_x[59] = 10'd1000; mem_y[59] = 9'd100;
        run_scan(0, lat, nrd, ndone);
        chk("wrap_coll", 32'(collision), 1);
        chk("wrap_hrow", 32'(hit_row), 5);
        chk("wrap_hcol", 32'(hit_col), 9);

        // Snapshot holds; mid-scan start ignored
        set_far();
        player_x = 10'd100; player_y = 9'd100;
        run_scan(1, lat, nrd, ndone);
        chk("snap_coll", 32'(collision), 0);
        chk("snap_ndone", 32'(ndone), 1);
        chk("snap_latency", 32'(lat), 62);
        chk("snap_busy_end", 32'(busy), 0);
        player_x = 10'd100; player_y = 9'd100;

        // Abort keeps previous result; IDLE with enable low clears it
        mem_x[25] = 10'd110; mem_y[25] = 9'd105;
        run_scan(0, lat, nrd, ndone);
        chk("pre_abort_coll", 32'(collision), 1);
        set_far();
        run_scan(2, lat, nrd, ndone);
        chk("abort_ndone", 32'(ndone), 0);
        chk("abort_coll", 32'(collision), 1);
        chk("abort_hrow", 32'(hit_row), 2);
        chk("abort_hcol", 32'(hit_col), 5);
        chk("abort_busy", 32'(busy), 0);
        @(negedge clk);
        enable = 1'b0;
        @(posedge clk); #1;
        chk("idle_dis_coll", 32'(collision), 0);
        chk("idle_dis_hrow", 32'(hit_row), 0);
        chk("idle_dis_hcol", 32'(hit_col), 0);
        enable = 1'b1;

        // Asynchronous reset mid-scan
        mem_x[25] = 10'd110; mem_y[25] = 9'd105;
        run_scan(0, lat, nrd, ndone);
        chk("pre_rst_coll", 32'(collision), 1);
        run_scan(3, lat, nrd, ndone);
        chk("rst_ndone", 32'(ndone), 0);
        chk("rst_coll_after", 32'(collision), 0);

        // Start in the DONE cycle is dropped
        set_far();
        run_scan(4, lat, nrd, ndone);
        chk("donestart_ndone", 32'(ndone), 1);
        chk("donestart_busy", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
